// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - EX operand forwarding and load-use / flush / mem-busy hazard control
// Optional stall counter (stall_cnt port) is built only when HAZARD_PERF_EN is defined.
module hazard_fwd_unit #(
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            flush_e,
  input  logic            mem_busy,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            stall_f,
  output logic            stall_d,
  output logic            bubble_e,
  output logic            flush_d
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]     stall_cnt
`endif
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t state, state_n;

  logic            ex_valid, ex_regwrite, ex_memread;
  logic [REGW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic            mem_valid, mem_regwrite;
  logic [REGW-1:0] mem_rd;
  logic            wb_valid, wb_regwrite;
  logic [REGW-1:0] wb_rd;

  logic advance;
  logic ex_bubble;
  logic load_use;
  logic mem_src_ok;
  logic wb_src_ok;

  // A stage may forward only if it holds a live instruction that writes a non-x0 register.
  assign mem_src_ok = mem_valid && mem_regwrite && (mem_rd != '0);
  assign wb_src_ok  = wb_valid && wb_regwrite && (wb_rd != '0);

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (wb_src_ok && (wb_rd == ex_rs1))
      fwd_a = 2'b10;
    if (mem_src_ok && (mem_rd == ex_rs1))
      fwd_a = 2'b01;
    if (wb_src_ok && (wb_rd == ex_rs2))
      fwd_b = 2'b10;
    if (mem_src_ok && (mem_rd == ex_rs2))
      fwd_b = 2'b01;
  end

  assign load_use = ex_valid && ex_memread && (ex_rd != '0) && id_valid &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= RUN;
    else
      state <= state_n;
  end

  // Priority: reset, then mem_busy freeze, then flush, then load-use stall.
  always_comb begin
    state_n   = state;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    bubble_e  = 1'b0;
    flush_d   = 1'b0;
    advance   = 1'b0;
    ex_bubble = 1'b0;
    if (rst) begin
      state_n = RUN;
    end else if (mem_busy) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
    end else begin
      advance = 1'b1;
      if (flush_e) begin
        flush_d   = 1'b1;
        ex_bubble = 1'b1;
        state_n   = RUN;
      end else if ((state == RUN) && load_use) begin
        stall_f   = 1'b1;
        stall_d   = 1'b1;
        bubble_e  = 1'b1;
        ex_bubble = 1'b1;
        state_n   = STALL;
      end else begin
        state_n = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      mem_valid    <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_rd       <= '0;
      wb_valid     <= 1'b0;
      wb_regwrite  <= 1'b0;
      wb_rd        <= '0;
    end else if (advance) begin
      wb_valid     <= mem_valid;
      wb_regwrite  <= mem_regwrite;
      wb_rd        <= mem_rd;
      mem_valid    <= ex_valid;
      mem_regwrite <= ex_regwrite;
      mem_rd       <= ex_rd;
      if (ex_bubble) begin
        ex_valid    <= 1'b0;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
        ex_rs1      <= '0;
        ex_rs2      <= '0;
        ex_rd       <= '0;
      end else begin
        ex_valid    <= id_valid;
        ex_regwrite <= id_regwrite;
        ex_memread  <= id_memread;
        ex_rs1      <= id_rs1;
        ex_rs2      <= id_rs2;
        ex_rd       <= id_rd;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall_f)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb/tb_hazard_fwd_unit.sv - scoreboard bench for hazard_fwd_unit
module tb_hazard_fwd_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0;
  logic [4:0] id_rs2 = '0;
  logic [4:0] id_rd = '0;
  logic       id_regwrite = 1'b0;
  logic       id_memread = 1'b0;
  logic       flush_e = 1'b0;
  logic       mem_busy = 1'b0;
  logic [1:0] fwd_a, fwd_b;
  logic       stall_f, stall_d, bubble_e, flush_d;
  logic [31:0] cnt_act;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt;
  assign cnt_act = stall_cnt;
`else
  assign cnt_act = '0;
`endif

  hazard_fwd_unit #(.REGW(5)) dut (
    .clk(clk),
    .rst(rst),
    .id_valid(id_valid),
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_rd(id_rd),
    .id_regwrite(id_regwrite),
    .id_memread(id_memread),
    .flush_e(flush_e),
    .mem_busy(mem_busy),
    .fwd_a(fwd_a),
    .fwd_b(fwd_b),
    .stall_f(stall_f),
    .stall_d(stall_d),
    .bubble_e(bubble_e),
    .flush_d(flush_d)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        sf;
    logic        sd;
    logic        be;
    logic        fd;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int passed = 0;
  int total = 0;
  logic [31:0] cnt_model = '0;

  task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp)
      passed++;
    else
      $display("FAIL %s step %0d: got %0h expected %0h", nm, id, act, exp);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("fwd_a", e.id, {30'd0, fwd_a}, {30'd0, e.fa});
      check("fwd_b", e.id, {30'd0, fwd_b}, {30'd0, e.fb});
      check("stall_f", e.id, {31'd0, stall_f}, {31'd0, e.sf});
      check("stall_d", e.id, {31'd0, stall_d}, {31'd0, e.sd});
      check("bubble_e", e.id, {31'd0, bubble_e}, {31'd0, e.be});
      check("flush_d", e.id, {31'd0, flush_d}, {31'd0, e.fd});
`ifdef HAZARD_PERF_EN
      check("stall_cnt", e.id, cnt_act, e.cnt);
`endif
    end
  end

  task automatic step(input int id, input logic r, input logic v, input int rs1, input int rs2,
                      input int rd, input logic rw, input logic mr, input logic fl, input logic mb,
                      input logic [1:0] fa, input logic [1:0] fb, input logic sf, input logic sd,
                      input logic be, input logic fd);
    exp_t e;
    rst         = r;
    id_valid    = v;
    id_rs1      = rs1[4:0];
    id_rs2      = rs2[4:0];
    id_rd       = rd[4:0];
    id_regwrite = rw;
    id_memread  = mr;
    flush_e     = fl;
    mem_busy    = mb;
    if (r)
      cnt_model = '0;
    e.id  = id;
    e.fa  = fa;
    e.fb  = fb;
    e.sf  = sf;
    e.sd  = sd;
    e.be  = be;
    e.fd  = fd;
    e.cnt = cnt_model;
    q.push_back(e);
    if (!r && sf)
      cnt_model = cnt_model + 32'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    // reset holds outputs low even with mem_busy high
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0);
    // x5 written twice, then consumer of x5 sees MEM priority
    step(1, 0, 1, 1, 2, 5, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    step(2, 0, 1, 3, 4, 5, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    step(3, 0, 1, 5, 9, 10, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    step(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0);
    // x7 reaches WB only; rd=0 writer never forwards
    step(5, 0, 1, 0, 0, 7, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    step(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    step(7, 0, 1, 0, 7, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    step(8, 0, 1, 0, 0, 8, 1, 0, 0, 0, 2'b00, 2'b10, 0, 0, 0, 0);
    step(9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    // lw x3 then use: one stall cycle, then WB forward
    step(10, 0, 1, 0, 0, 3, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    step(11, 0, 1, 3, 0, 4, 1, 0, 0, 0, 2'b00, 2'b00, 1, 1, 1, 0);
    step(12, 0, 1, 3, 0, 4, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    step(13, 0, 1, 0, 4, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0, 0);
    step(14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0, 0, 0);
    // load-use coincident with flush: flush wins
    step(15, 0, 1, 0, 0, 6, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    step(16, 0, 1, 0, 6, 9, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 1);
    step(17, 0, 1, 6, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    step(18, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0, 0);
    // mem_busy for three cycles freezes metadata; flush under busy is ignored
    step(19, 0, 1, 0, 0, 11, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    step(20, 0, 1, 11, 11, 12, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    step(21, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b01, 1, 1, 0, 0);
    step(22, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b01, 2'b01, 1, 1, 0, 0);
    step(23, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b01, 1, 1, 0, 0);
    step(24, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0, 0, 0);
    // reset asserted while in STALL with mem_busy high
    step(25, 0, 1, 0, 0, 2, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    step(26, 0, 1, 2, 0, 5, 1, 0, 0, 0, 2'b00, 2'b00, 1, 1, 1, 0);
    step(27, 1, 1, 2, 0, 5, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0);
    step(28, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    step(29, 0, 1, 2, 0, 5, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    step(30, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    total++;
    if (q.size() == 0)
      passed++;
    else
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 SHALL have parameter REGW, default 5, meaning register-index width.
REQ-002 SHALL have clk, input, 1, the single clock; all state on its rising edge.
REQ-003 SHALL have rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread as inputs (1/REGW/REGW/REGW/1/1) describing the decode-stage instruction.
REQ-005 SHALL have flush_e, input, 1: taken branch resolved in EX; kill the ID and EX instructions.
REQ-006 SHALL have mem_busy, input, 1: data memory not ready; freeze the whole pipeline.
REQ-007 SHALL have fwd_a, fwd_b, outputs, 2: operand selects for the EX 4:1 operand muxes.
REQ-008 SHALL have stall_f, stall_d, bubble_e, flush_d, outputs, 1: hold PC, hold ID register, insert EX bubble, clear ID register.
REQ-009 SHALL have stall_cnt, output, 32, present only under the configuration macro.

Function
REQ-010 SHALL hold internal metadata registers for EX, MEM and WB: valid, rs1, rs2 (EX only), rd, regwrite, memread.
REQ-011 SHALL advance metadata ID->EX->MEM->WB each cycle when mem_busy=0 and no stall is asserted.
REQ-012 SHALL load a bubble (valid=0) into EX when bubble_e=1 or flush_e=1, and still advance MEM and WB.
REQ-013 SHALL encode selects as: 00 register file, 01 MEM-stage ALU result, 10 WB result, 11 never driven.
REQ-014 SHALL set fwd_a=01 when MEM valid, regwrite, rd!=0, rd==EX rs1; else 10 on the same test against WB; else 00 (same rules for fwd_b/rs2).
REQ-015 SHALL give MEM priority over WB when both match.
REQ-016 SHALL never forward for register x0, or from an invalid or non-writing stage.
REQ-017 SHALL compute fwd_a/fwd_b combinationally from registered EX/MEM/WB metadata (zero added latency).
REQ-018 SHALL detect load-use when EX valid, memread, rd!=0, and rd equals id_rs1 or id_rs2 with id_valid=1.
REQ-019 SHALL implement FSM states RUN and STALL.
REQ-020 SHALL, in RUN with load-use, flush_e=0 and mem_busy=0, assert stall_f, stall_d, bubble_e that cycle and go to STALL.
REQ-021 SHALL, in STALL, deassert the stall outputs (EX now holds the bubble) and return to RUN; the consumer then takes its operand via the WB forward (10).
REQ-022 SHALL, when flush_e=1, assert flush_d, suppress load-use stall outputs, and force state RUN; flush wins over stall.
REQ-023 SHALL, when mem_busy=1, assert stall_f and stall_d, freeze all metadata and FSM state, and deassert bubble_e and flush_d.
REQ-024 SHALL drive flush_e and mem_busy together as mem_busy behaviour, with the flush taking effect in the first cycle mem_busy=0 and flush_e=1.

Reset
REQ-025 SHALL, on rst=1, immediately clear all stage valid bits and metadata, set state RUN, and drive all outputs to 0, including stall_cnt.
REQ-026 SHALL, when rst asserts mid-stall, abandon the stall; the first cycle after release is RUN with no bubble.

Configuration
REQ-027 SHALL compile the stall counter only when HAZARD_PERF_EN is defined: stall_cnt increments by 1 each cycle with stall_f=1 and wraps from 0xFFFFFFFF to 0.
REQ-028 SHALL, without HAZARD_PERF_EN, have no stall_cnt port and no counter register; all other behaviour is identical.

Verification
REQ-029 SHALL pass: add x5 in MEM, EX rs1=5 -> fwd_a=01; same with x5 also in WB -> fwd_a=01.
REQ-030 SHALL pass: add x7 in WB only, EX rs2=7 -> fwd_b=10; rd=0 writer with EX rs1=0 -> fwd_a=00.
REQ-031 SHALL pass: lw x3 in EX, ID rs1=3 -> stall_f/stall_d/bubble_e=1 for exactly 1 cycle; 2 cycles later EX consumer fwd_a=10.
REQ-032 SHALL pass: load-use coincident with flush_e=1 -> flush_d=1, stall_f=0, bubble into EX, state RUN.
REQ-033 SHALL pass: mem_busy high 3 cycles -> stall_f=stall_d=1 for 3 cycles, metadata unchanged; with HAZARD_PERF_EN, stall_cnt +3.
REQ-034 SHALL pass: rst asserted in STALL -> all outputs 0 asynchronously; first post-reset cycle has no stall.
